tinynpu_seq_ctrl: RTL and testbench
===================================

Name: tinynpu_seq_ctrl

Overview:
Multi-layer sequencing controller for the TinyNPU datapath; the next generation of the single-pass NPU controller. Drives x/w FIFO writes, MAC streaming, output-stream capture back into the x FIFO, and the final output drain. It runs a programmed number of layers autonomously, with a configurable MAC pipeline latency and a ready/valid output handshake.

Parameters:
SIZE, 4, PE/FIFO lane count; power of two, >=2
MAC_LAT, 3, cycles from last MAC issue to ostream_req; >=1
MAX_LAYERS, 8, maximum programmable layer count; >=1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
cfg_val  in  1  layer-count config valid
cfg_layers  in  $clog2(MAX_LAYERS+1)  number of layers
cfg_rdy  out  1  config accepted (IDLE only)
d2c_x_load_val  in  1  host x word valid
d2c_w_load_val  in  1  host w word valid
d2c_w_load_sel  in  $clog2(SIZE)  target w FIFO
d2c_start  in  1  begin MAC pass for current layer
d2c_x_fifo_empty  in  1  x FIFO empty
d2c_w_fifo_empty  in  SIZE  per-lane w FIFO empty
c2d_x_sel  out  1  0=host, 1=MAC output stream into x FIFO
c2d_x_fifo_wen  out  1  x FIFO write
c2d_w_fifo_wen  out  SIZE  per-lane w FIFO write
c2d_istream_val  out  1  MAC input valid
c2d_fifo_ren  out  1  x and w FIFO read
c2d_ostream_req  out  1  one-cycle MAC result capture
c2d_ostream_sel  out  $clog2(SIZE)+1  output lane select
c2d_mac_rst  out  1  clear accumulators
c2d_z_out_sel  out  1  route FIFO data to output port
out_val  out  1  output word valid
out_rdy  in  1  consumer ready
done  out  1  one-cycle pulse when the run completes
trace_state  out  4  current state, zero-extended

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters 0; every output 0 except cfg_rdy=1.
- empty = x_fifo_empty AND all w_fifo_empty.
- States: IDLE=0, LD0=1, MAC=2, DRAIN=3, LD1=4, OUT=5.
- IDLE: cfg_rdy=1. cfg_val -> latch layers = max(cfg_layers,1), clamp to MAX_LAYERS; layer_cnt=0; go to LD0. cfg_val outside IDLE is ignored.
- LD0: x_sel=0; x_fifo_wen=d2c_x_load_val; w_fifo_wen[i]=w_load_val & (sel==i). Out-of-range sel writes nothing. d2c_start -> MAC. Loads in the transition cycle are still honoured.
- MAC: istream_val=fifo_ren=~empty. When empty -> DRAIN, lat_cnt=0.
- DRAIN: lat_cnt increments each cycle. At lat_cnt==MAC_LAT-1: ostream_req=1 for that cycle, ostream_sel cleared to 0, go to LD1.
- LD1: x_sel=1. While ostream_sel<SIZE: x_fifo_wen=1 and ostream_sel increments. Host w loads are allowed as in LD0. Once ostream_sel==SIZE: mac_rst=1 every cycle.
  - If layer_cnt==layers-1, go to OUT.
  - Else, on d2c_start: layer_cnt+=1, go to MAC.
  - Without start, hold.
- OUT: z_out_sel=1; out_val=~empty; fifo_ren=~empty & out_rdy. With out_rdy=0, out_val holds and nothing is consumed. When empty: done=1 for one cycle, go to IDLE.
- Undefined state encodings -> IDLE.
- Counters saturate, never wrap: ostream_sel stops at SIZE; lat_cnt is cleared on DRAIN entry.
- c2d_x_sel = 0 in every state other than LD1.

Decomposition:
- Package tinynpu_ctrl_pkg holds:
  - state enum (4-bit);
  - localparams LAYER_W=$clog2(MAX_LAYERS+1), SEL_W=$clog2(SIZE)+1, LAT_W=$clog2(MAC_LAT+1).
- One sub-module, tinynpu_ctr: parametric-width up-counter with async active-low reset, sync clear, enable, and saturate-at-limit input. Instantiated for lat_cnt, ostream_sel and layer_cnt.

Test Plan:
- Reset mid-MAC (rst low for 1 cycle while state=MAC) -> trace_state=0 immediately (async), cfg_rdy=1, all other outputs 0.
- cfg_layers=1, SIZE=4, MAC_LAT=3: load 4 x and 4 per-lane w words, pulse start.
  - istream_val high for 4 cycles, then ostream_req exactly 3 cycles after empty.
  - Then 4 x_fifo_wen with x_sel=1 and ostream_sel 0..3, mac_rst, then OUT.
- Same run with out_rdy low for 5 cycles in OUT -> out_val held, fifo_ren=0; resumes when ready; done pulses once.
- cfg_layers=3 -> start needed in LD1 twice; three ostream_req pulses; OUT entered only after layer_cnt=2.
- cfg_layers=0 -> behaves as 1 layer. cfg_layers=MAX_LAYERS+1 on a width-permitting config -> clamped to MAX_LAYERS.
- w_load_sel=4 with SIZE=4 (wide sel config) -> no w_fifo_wen asserted. cfg_val during MAC -> ignored, cfg_rdy=0.

Source files
------------

// File: rtl/tinynpu_ctrl_pkg.sv
// tinynpu_ctrl_pkg: shared state encoding, default parameters and width helpers for the TinyNPU sequencer
package tinynpu_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LD0   = 4'd1,
    MAC   = 4'd2,
    DRAIN = 4'd3,
    LD1   = 4'd4,
    OUT   = 4'd5
  } state_t;
  function automatic int layer_w(input int max_layers);
    return $clog2(max_layers + 1);
  endfunction
  function automatic int sel_w(input int size);
    return $clog2(size) + 1;
  endfunction
  function automatic int lat_w(input int mac_lat);
    return $clog2(mac_lat + 1);
  endfunction
  localparam int SIZE_DEF       = 4;
  localparam int MAC_LAT_DEF    = 3;
  localparam int MAX_LAYERS_DEF = 8;
  localparam int LAYER_W        = layer_w(MAX_LAYERS_DEF);
  localparam int SEL_W          = sel_w(SIZE_DEF);
  localparam int LAT_W          = lat_w(MAC_LAT_DEF);
endpackage

// File: rtl/tinynpu_ctr.sv
// tinynpu_ctr: up-counter with sync clear and enable that saturates at lim instead of wrapping
module tinynpu_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != lim) cnt <= cnt + 1'b1;
endmodule

// File: rtl/tinynpu_seq_ctrl.sv
// tinynpu_seq_ctrl: multi-layer TinyNPU sequencer driving FIFO loads, MAC streaming, write-back and drain
module tinynpu_seq_ctrl
  import tinynpu_ctrl_pkg::*;
#(
  parameter int SIZE       = SIZE_DEF,
  parameter int MAC_LAT    = MAC_LAT_DEF,
  parameter int MAX_LAYERS = MAX_LAYERS_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_val,
  input  logic [$clog2(MAX_LAYERS+1)-1:0] cfg_layers,
  output logic                            cfg_rdy,
  input  logic                            d2c_x_load_val,
  input  logic                            d2c_w_load_val,
  input  logic [$clog2(SIZE)-1:0]         d2c_w_load_sel,
  input  logic                            d2c_start,
  input  logic                            d2c_x_fifo_empty,
  input  logic [SIZE-1:0]                 d2c_w_fifo_empty,
  output logic                            c2d_x_sel,
  output logic                            c2d_x_fifo_wen,
  output logic [SIZE-1:0]                 c2d_w_fifo_wen,
  output logic                            c2d_istream_val,
  output logic                            c2d_fifo_ren,
  output logic                            c2d_ostream_req,
  output logic [$clog2(SIZE):0]           c2d_ostream_sel,
  output logic                            c2d_mac_rst,
  output logic                            c2d_z_out_sel,
  output logic                            out_val,
  input  logic                            out_rdy,
  output logic                            done,
  output logic [3:0]                      trace_state
);
  localparam int LW = layer_w(MAX_LAYERS);
  localparam int SW = sel_w(SIZE);
  localparam int TW = lat_w(MAC_LAT);
  state_t        state;
  logic [LW-1:0] layers, layers_in, layer_cnt;
  logic [TW-1:0] lat_cnt;
  logic [SW-1:0] sel_cnt;
  logic          empty, lat_hit, sel_full, last, adv, loading;
  assign empty     = d2c_x_fifo_empty & (&d2c_w_fifo_empty);
  assign lat_hit   = lat_cnt == TW'(MAC_LAT - 1);
  assign sel_full  = sel_cnt >= SW'(SIZE);
  assign last      = layer_cnt == layers - 1'b1;
  assign adv       = state == LD1 && sel_full && !last && d2c_start;
  assign loading   = state == LD0 || state == LD1;
  assign layers_in = cfg_layers == '0 ? LW'(1) :
                     cfg_layers > LW'(MAX_LAYERS) ? LW'(MAX_LAYERS) : cfg_layers;
  tinynpu_ctr #(.W(TW)) u_lat (
    .clk, .rst, .clr(state == MAC && empty), .en(state == DRAIN), .lim(TW'(MAC_LAT)), .cnt(lat_cnt)
  );
  tinynpu_ctr #(.W(SW)) u_sel (
    .clk, .rst, .clr(state == DRAIN && lat_hit), .en(state == LD1), .lim(SW'(SIZE)), .cnt(sel_cnt)
  );
  tinynpu_ctr #(.W(LW)) u_layer (
    .clk, .rst, .clr(state == IDLE && cfg_val), .en(adv), .lim(LW'(MAX_LAYERS)), .cnt(layer_cnt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      layers <= '0;
    end else begin
      case (state)
        IDLE:    if (cfg_val) begin
                   layers <= layers_in;
                   state  <= LD0;
                 end
        LD0:     if (d2c_start) state <= MAC;
        MAC:     if (empty) state <= DRAIN;
        DRAIN:   if (lat_hit) state <= LD1;
        LD1:     if (sel_full) state <= last ? OUT : d2c_start ? MAC : LD1;
        OUT:     if (empty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // sel values beyond the lane count match no lane and write nothing
  always_comb begin
    c2d_w_fifo_wen = '0;
    for (int i = 0; i < SIZE; i++)
      c2d_w_fifo_wen[i] = loading && d2c_w_load_val && int'(d2c_w_load_sel) == i;
  end
  assign cfg_rdy         = state == IDLE;
  assign c2d_x_sel       = state == LD1;
  assign c2d_x_fifo_wen  = state == LD0 ? d2c_x_load_val : state == LD1 && !sel_full;
  assign c2d_istream_val = state == MAC && !empty;
  assign c2d_fifo_ren    = !empty && (state == MAC || (state == OUT && out_rdy));
  assign c2d_ostream_req = state == DRAIN && lat_hit;
  assign c2d_ostream_sel = sel_cnt;
  assign c2d_mac_rst     = state == LD1 && sel_full;
  assign c2d_z_out_sel   = state == OUT;
  assign out_val         = state == OUT && !empty;
  assign done            = state == OUT && empty;
  assign trace_state     = state;
endmodule

// File: tb/tb_tinynpu_seq_ctrl.sv
// tb_tinynpu_seq_ctrl: vector table for a one-layer run plus directed multi-cycle sequences
module tb_tinynpu_seq_ctrl;
  localparam logic [9:0] F_CFG = 10'h200, F_XSEL = 10'h100, F_XWEN = 10'h080, F_IST = 10'h040,
                         F_REN = 10'h020, F_OREQ = 10'h010, F_MRST = 10'h008, F_Z = 10'h004,
                         F_OV = 10'h002, F_DONE = 10'h001;
  logic       clk = 0, rst = 0;
  logic       cfg_val = 0, cfg_rdy;
  logic [3:0] cfg_layers = 0;
  logic       d2c_x_load_val = 0, d2c_w_load_val = 0, d2c_start = 0, d2c_x_fifo_empty = 1;
  logic [1:0] d2c_w_load_sel = 0;
  logic [3:0] d2c_w_fifo_empty = 4'hf, c2d_w_fifo_wen;
  logic       c2d_x_sel, c2d_x_fifo_wen, c2d_istream_val, c2d_fifo_ren, c2d_ostream_req;
  logic [2:0] c2d_ostream_sel;
  logic       c2d_mac_rst, c2d_z_out_sel, out_val, out_rdy = 1, done;
  logic [3:0] trace_state;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  tinynpu_seq_ctrl #(.SIZE(4), .MAC_LAT(3), .MAX_LAYERS(8)) dut (
    .clk(clk), .rst(rst), .cfg_val(cfg_val), .cfg_layers(cfg_layers), .cfg_rdy(cfg_rdy),
    .d2c_x_load_val(d2c_x_load_val), .d2c_w_load_val(d2c_w_load_val),
    .d2c_w_load_sel(d2c_w_load_sel), .d2c_start(d2c_start),
    .d2c_x_fifo_empty(d2c_x_fifo_empty), .d2c_w_fifo_empty(d2c_w_fifo_empty),
    .c2d_x_sel(c2d_x_sel), .c2d_x_fifo_wen(c2d_x_fifo_wen), .c2d_w_fifo_wen(c2d_w_fifo_wen),
    .c2d_istream_val(c2d_istream_val), .c2d_fifo_ren(c2d_fifo_ren),
    .c2d_ostream_req(c2d_ostream_req), .c2d_ostream_sel(c2d_ostream_sel),
    .c2d_mac_rst(c2d_mac_rst), .c2d_z_out_sel(c2d_z_out_sel), .out_val(out_val),
    .out_rdy(out_rdy), .done(done), .trace_state(trace_state)
  );
  typedef struct {
    logic       cv;
    logic [3:0] cl;
    logic       xl, wl;
    logic [1:0] ws;
    logic       st, xe;
    logic [3:0] we;
    logic       rdy;
    logic [3:0] es;
    logic [9:0] ef;
    logic [3:0] ew;
    logic [2:0] eo;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t v(input int cv, cl, xl, wl, ws, st, xe, we, rdy, es, ef, ew, eo);
    vec_t r;
    r.cv = 1'(cv); r.cl = 4'(cl); r.xl = 1'(xl); r.wl = 1'(wl); r.ws = 2'(ws);
    r.st = 1'(st); r.xe = 1'(xe); r.we = 4'(we); r.rdy = 1'(rdy);
    r.es = 4'(es); r.ef = 10'(ef); r.ew = 4'(ew); r.eo = 3'(eo);
    return r;
  endfunction
  function automatic logic [9:0] flags();
    return {cfg_rdy, c2d_x_sel, c2d_x_fifo_wen, c2d_istream_val, c2d_fifo_ren,
            c2d_ostream_req, c2d_mac_rst, c2d_z_out_sel, out_val, done};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(input vec_t x, input int idx);
    cfg_val = x.cv; cfg_layers = x.cl; d2c_x_load_val = x.xl; d2c_w_load_val = x.wl;
    d2c_w_load_sel = x.ws; d2c_start = x.st; d2c_x_fifo_empty = x.xe;
    d2c_w_fifo_empty = x.we; out_rdy = x.rdy;
    @(negedge clk);
    chk($sformatf("vec%0d state", idx), 32'(trace_state), 32'(x.es));
    chk($sformatf("vec%0d flags", idx), 32'(flags()), 32'(x.ef));
    chk($sformatf("vec%0d w_wen", idx), 32'(c2d_w_fifo_wen), 32'(x.ew));
    chk($sformatf("vec%0d osel", idx), 32'(c2d_ostream_sel), 32'(x.eo));
    step();
  endtask
  task automatic wait_mrst(input string name);
    int n = 0;
    @(negedge clk);
    while (!c2d_mac_rst && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(c2d_mac_rst), 32'd1);
  endtask
  task automatic run_layers(input int cl, input int exp_n);
    int reqs = 0, dones = 0, n = 0;
    cfg_val = 1; cfg_layers = 4'(cl);
    step();
    cfg_val = 0; d2c_start = 1;
    while (dones == 0 && n < 400) begin
      @(negedge clk);
      reqs += int'(c2d_ostream_req);
      dones += int'(done);
      n++;
    end
    d2c_start = 0;
    chk($sformatf("cfg%0d passes", cl), 32'(reqs), 32'(exp_n));
    chk($sformatf("cfg%0d done", cl), 32'(dones), 32'd1);
    step();
    chk($sformatf("cfg%0d idle", cl), 32'(trace_state), 32'd0);
  endtask
  initial begin
    // one-layer run: 4 loads, 4 MAC cycles, 3-cycle latency, write-back, stalled drain
    vecs.push_back(v(0,0, 0,0,0,0, 1,15,1, 0, F_CFG, 0,0));
    vecs.push_back(v(1,1, 0,0,0,0, 1,15,1, 0, F_CFG, 0,0));
    vecs.push_back(v(0,0, 1,1,0,0, 1,15,1, 1, F_XWEN, 1,0));
    vecs.push_back(v(0,0, 1,1,1,0, 0,14,1, 1, F_XWEN, 2,0));
    vecs.push_back(v(0,0, 1,1,2,0, 0,12,1, 1, F_XWEN, 4,0));
    vecs.push_back(v(0,0, 1,1,3,1, 0, 8,1, 1, F_XWEN, 8,0));
    vecs.push_back(v(1,5, 0,0,0,0, 0, 0,1, 2, F_IST|F_REN, 0,0));
    vecs.push_back(v(0,0, 0,0,0,0, 0, 0,1, 2, F_IST|F_REN, 0,0));
    vecs.push_back(v(0,0, 0,0,0,0, 0, 0,1, 2, F_IST|F_REN, 0,0));
    vecs.push_back(v(0,0, 0,0,0,0, 0, 0,1, 2, F_IST|F_REN, 0,0));
    vecs.push_back(v(0,0, 0,0,0,0, 1,15,1, 2, 0, 0,0));
    vecs.push_back(v(0,0, 0,0,0,0, 1,15,1, 3, 0, 0,0));
    vecs.push_back(v(0,0, 0,0,0,0, 1,15,1, 3, 0, 0,0));
    vecs.push_back(v(0,0, 0,0,0,0, 1,15,1, 3, F_OREQ, 0,0));
    vecs.push_back(v(0,0, 0,1,2,0, 1,15,1, 4, F_XSEL|F_XWEN, 4,0));
    vecs.push_back(v(0,0, 0,0,0,0, 1,15,1, 4, F_XSEL|F_XWEN, 0,1));
    vecs.push_back(v(0,0, 0,0,0,0, 0,15,1, 4, F_XSEL|F_XWEN, 0,2));
    vecs.push_back(v(0,0, 0,0,0,0, 0,15,1, 4, F_XSEL|F_XWEN, 0,3));
    vecs.push_back(v(0,0, 0,0,0,0, 0,15,1, 4, F_XSEL|F_MRST, 0,4));
    vecs.push_back(v(0,0, 0,0,0,0, 0,15,1, 5, F_Z|F_OV|F_REN, 0,4));
    vecs.push_back(v(0,0, 0,1,0,0, 0,15,0, 5, F_Z|F_OV, 0,4));
    vecs.push_back(v(0,0, 0,0,0,0, 0,15,0, 5, F_Z|F_OV, 0,4));
    vecs.push_back(v(0,0, 0,0,0,0, 0,15,0, 5, F_Z|F_OV, 0,4));
    vecs.push_back(v(0,0, 0,0,0,0, 0,15,0, 5, F_Z|F_OV, 0,4));
    vecs.push_back(v(0,0, 0,0,0,0, 0,15,0, 5, F_Z|F_OV, 0,4));
    vecs.push_back(v(0,0, 0,0,0,0, 0,15,1, 5, F_Z|F_OV|F_REN, 0,4));
    vecs.push_back(v(0,0, 0,0,0,0, 1,15,1, 5, F_Z|F_DONE, 0,4));
    vecs.push_back(v(0,0, 0,0,0,0, 1,15,1, 0, F_CFG, 0,4));
    vecs.push_back(v(0,0, 0,0,0,0, 1,15,1, 0, F_CFG, 0,4));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", 32'(trace_state), 32'd0);
    chk("reset flags", 32'(flags()), 32'(F_CFG));
    rst = 1;
    step();
    foreach (vecs[i]) apply(vecs[i], i);
    // asynchronous reset while streaming
    cfg_val = 1; cfg_layers = 2;
    step();
    cfg_val = 0; d2c_x_fifo_empty = 0; d2c_w_fifo_empty = 0; d2c_start = 1;
    step();
    d2c_start = 0;
    @(negedge clk);
    chk("pre-reset state", 32'(trace_state), 32'd2);
    chk("pre-reset flags", 32'(flags()), 32'(F_IST|F_REN));
    #1 rst = 0;
    #1;
    chk("async reset state", 32'(trace_state), 32'd0);
    chk("async reset flags", 32'(flags()), 32'(F_CFG));
    chk("async reset osel", 32'(c2d_ostream_sel), 32'd0);
    chk("async reset w_wen", 32'(c2d_w_fifo_wen), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    d2c_x_fifo_empty = 1; d2c_w_fifo_empty = 4'hf;
    step();
    // two layers: LD1 holds without start, then start re-enters MAC
    cfg_val = 1; cfg_layers = 2;
    step();
    cfg_val = 0; d2c_start = 1;
    step();
    d2c_start = 0;
    wait_mrst("hold reach mac_rst");
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold%0d state", i), 32'(trace_state), 32'd4);
      chk($sformatf("hold%0d mac_rst", i), 32'(c2d_mac_rst), 32'd1);
      @(negedge clk);
    end
    d2c_start = 1;
    step();
    d2c_start = 0;
    @(negedge clk);
    chk("restart state", 32'(trace_state), 32'd2);
    wait_mrst("second pass mac_rst");
    @(negedge clk);
    chk("second pass out", 32'(trace_state), 32'd5);
    chk("second pass done", 32'(flags()), 32'(F_Z|F_DONE));
    @(negedge clk);
    chk("after done state", 32'(trace_state), 32'd0);
    chk("after done pulse", 32'(done), 32'd0);
    step();
    run_layers(0, 1);
    run_layers(3, 3);
    run_layers(8, 8);
    run_layers(9, 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
